// File: rtl/core_scheduler_if.sv
// Host/processor bundle for core_scheduler: job control inputs, per-core command lines and job status.
interface core_scheduler_if #(parameter int TASK_W = 8);
  logic              start;
  logic [TASK_W-1:0] num_tasks;
  logic [3:0]        core_enable;
  logic [3:0]        end_process;
  logic [1:0]        status0, status1, status2, status3;
  logic [TASK_W-1:0] task_id0, task_id1, task_id2, task_id3;
  logic              busy, done, err;
  logic [TASK_W-1:0] completed;

  modport master (
    output start, num_tasks, core_enable, end_process,
    input  status0, status1, status2, status3,
           task_id0, task_id1, task_id2, task_id3, busy, done, completed, err
  );
  modport slave (
    input  start, num_tasks, core_enable, end_process,
    output status0, status1, status2, status3,
           task_id0, task_id1, task_id2, task_id3, busy, done, completed, err
  );
endinterface

// File: rtl/core_scheduler.sv
// 4-core row-task scheduler: dispatches tasks to free cores and counts completions.
// Optional per-slot watchdog enabled by defining CORE_SCHED_WATCHDOG_EN.
module core_scheduler #(
  parameter int TASK_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input logic             clk,
  input logic             reset,
  core_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} top_t;
  typedef enum logic [1:0] {FREE, LAUNCH, RUN_WAIT} slot_t;

  top_t                   state, state_nxt;
  slot_t                  slot [4];
  logic [3:0]             en_q, armed, comp, tmo, fin, free_en, disp_oh;
  logic [TASK_W-1:0]      num_q, next_task, completed_q;
  logic [3:0][1:0]        status_q;
  logic [3:0][TASK_W-1:0] task_q;
  logic                   busy_q, done_q, err_q;
  logic                   accept, dispatch_ok, all_done;
  logic [2:0]             pop;
  logic [TASK_W:0]        cmp_sum;

  // armed gates completion so a flag still high from the previous task is not counted
  always_comb begin
    comp    = '0;
    free_en = '0;
    for (int i = 0; i < 4; i++) begin
      comp[i]    = (slot[i] == RUN_WAIT) && armed[i] && bus.end_process[i];
      free_en[i] = en_q[i] && (slot[i] == FREE);
    end
  end

`ifdef CORE_SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [3:0][CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) wd_cnt <= '0;
    else
      for (int i = 0; i < 4; i++)
        if (slot[i] == LAUNCH)        wd_cnt[i] <= '0;
        else if (slot[i] == RUN_WAIT) wd_cnt[i] <= wd_cnt[i] + CNT_W'(1);
  end

  always_comb begin
    tmo = '0;
    for (int i = 0; i < 4; i++)
      tmo[i] = (slot[i] == RUN_WAIT) && !comp[i] && (wd_cnt[i] == CNT_W'(TIMEOUT - 1));
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo = '0;
`endif

  // a timed-out task still counts toward completion so the job terminates
  assign fin     = comp | tmo;
  assign pop     = 3'(fin[0]) + 3'(fin[1]) + 3'(fin[2]) + 3'(fin[3]);
  assign cmp_sum = {1'b0, completed_q} + (TASK_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.num_tasks == '0) ? FINISH : RUN;
      RUN:     if (all_done) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // downward scan leaves the lowest-index free core as the single dispatch target
  always_comb begin
    accept      = (state == IDLE) && bus.start && (bus.core_enable != '0);
    dispatch_ok = (state == RUN) && (next_task < num_q);
    all_done    = (state == RUN) && (cmp_sum == {1'b0, num_q});
    disp_oh     = '0;
    for (int i = 3; i >= 0; i--)
      if (free_en[i] && dispatch_ok) disp_oh = 4'b0001 << i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q        <= '0;
      num_q       <= '0;
      next_task   <= '0;
      completed_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      armed       <= '0;
      status_q    <= '0;
      task_q      <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= FREE;
    end else begin
      done_q <= (state == FINISH);
      if (accept) begin
        num_q       <= bus.num_tasks;
        en_q        <= bus.core_enable;
        next_task   <= '0;
        completed_q <= '0;
        err_q       <= 1'b0;
        busy_q      <= 1'b1;
      end
      if (state == FINISH) busy_q <= 1'b0;
      if (state == RUN) completed_q <= cmp_sum[TASK_W-1:0];
      if (|tmo) err_q <= 1'b1;
      if (|disp_oh) next_task <= next_task + TASK_W'(1);
      for (int i = 0; i < 4; i++) begin
        case (slot[i])
          FREE: if (disp_oh[i]) begin
            slot[i]     <= LAUNCH;
            status_q[i] <= 2'b10;
            task_q[i]   <= next_task;
            armed[i]    <= 1'b0;
          end
          LAUNCH: begin
            slot[i]     <= RUN_WAIT;
            status_q[i] <= 2'b01;
          end
          RUN_WAIT:
            if (fin[i]) begin
              slot[i]     <= FREE;
              status_q[i] <= 2'b00;
            end else if (!bus.end_process[i]) armed[i] <= 1'b1;
          default: slot[i] <= FREE;
        endcase
      end
    end
  end

  assign bus.status0   = status_q[0];
  assign bus.status1   = status_q[1];
  assign bus.status2   = status_q[2];
  assign bus.status3   = status_q[3];
  assign bus.task_id0  = task_q[0];
  assign bus.task_id1  = task_q[1];
  assign bus.task_id2  = task_q[2];
  assign bus.task_id3  = task_q[3];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.completed = completed_q;
  assign bus.err       = err_q;
endmodule
